// File: rtl/pp_rca_pkg.sv
`default_nettype none
// ============================================================================
// Module   : pp_rca_pkg
// Brief    : Shared defaults, stage-count helper and stage control record for
//            the pipelined ripple-carry adder. Macro: PP_RCA_OVF_EN.
// Revision : 1.0
// ============================================================================
package pp_rca_pkg;

    localparam int PP_RCA_WIDTH = 16;
    localparam int PP_RCA_SEG   = 4;

    function automatic int pp_rca_nstg(input int width, input int seg);
        return (seg < 1) ? 1 : width / seg;
    endfunction

    // Operand remainder and partial sum are WIDTH-dependent, so they travel
    // beside this record as parallel vectors.
    typedef struct packed {
        logic valid;
        logic carry;
`ifdef PP_RCA_OVF_EN
        logic ovf;
`endif
    } pp_rca_ctl_t;

endpackage
`default_nettype wire

// File: rtl/pp_rca_stage.sv
`default_nettype none
// ============================================================================
// Module   : pp_rca_stage
// Brief    : One SEG-bit adder segment plus its enable-gated stage register.
//            Macro: PP_RCA_OVF_EN adds the signed-overflow flag.
// Revision : 1.0
// ============================================================================
module pp_rca_stage
    import pp_rca_pkg::*;
#(
    parameter int WIDTH = PP_RCA_WIDTH,
    parameter int SEG   = PP_RCA_SEG,
    parameter int IDX   = 0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en_i,
    input  pp_rca_ctl_t      ctl_i,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    input  logic [WIDTH-1:0] sum_i,
    output pp_rca_ctl_t      ctl_o,
    output logic [WIDTH-1:0] a_o,
    output logic [WIDTH-1:0] b_o,
    output logic [WIDTH-1:0] sum_o
);

    logic [SEG-1:0]   seg_a_w;
    logic [SEG-1:0]   seg_b_w;
    logic [SEG-1:0]   seg_s_w;
    logic             co_w;
    pp_rca_ctl_t      ctl_d;
    pp_rca_ctl_t      ctl_q;
    logic [WIDTH-1:0] sum_d;
    logic [WIDTH-1:0] sum_q;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;

    assign seg_a_w = a_i[IDX*SEG +: SEG];
    assign seg_b_w = b_i[IDX*SEG +: SEG];
    assign {co_w, seg_s_w} = {1'b0, seg_a_w} + {1'b0, seg_b_w} + {{SEG{1'b0}}, ctl_i.carry};

    always_comb begin
        ctl_d       = ctl_i;
        ctl_d.carry = co_w;
`ifdef PP_RCA_OVF_EN
        // Carry into the segment MSB is recovered from its sum and operand bits.
        ctl_d.ovf   = (seg_s_w[SEG-1] ^ seg_a_w[SEG-1] ^ seg_b_w[SEG-1]) ^ co_w;
`endif
        sum_d                  = sum_i;
        sum_d[IDX*SEG +: SEG]  = seg_s_w;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ctl_q <= '0;
            a_q   <= '0;
            b_q   <= '0;
            sum_q <= '0;
        end else if (en_i) begin
            ctl_q <= ctl_d;
            a_q   <= a_i;
            b_q   <= b_i;
            sum_q <= sum_d;
        end
    end

    assign ctl_o = ctl_q;
    assign a_o   = a_q;
    assign b_o   = b_q;
    assign sum_o = sum_q;

endmodule
`default_nettype wire

// File: rtl/pp_rca_pipe.sv
`default_nettype none
// ============================================================================
// Module   : pp_rca_pipe
// Brief    : Parametrised pipelined ripple-carry adder/subtractor with
//            valid/ready flow control. Macro: PP_RCA_OVF_EN adds ovf_o.
// Revision : 1.0
// ============================================================================
module pp_rca_pipe
    import pp_rca_pkg::*;
#(
    parameter int WIDTH = PP_RCA_WIDTH,
    parameter int SEG   = PP_RCA_SEG
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid_i,
    output logic             in_ready_o,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    input  logic             cin_i,
    input  logic             sub_i,
    output logic             out_valid_o,
    input  logic             out_ready_i,
    output logic [WIDTH-1:0] s_o,
    output logic             cout_o
`ifdef PP_RCA_OVF_EN
    ,
    output logic             ovf_o
`endif
);

    localparam int NSTG = pp_rca_nstg(WIDTH, SEG);

    if ((SEG < 1) ? 1'b1 : ((WIDTH % SEG) != 0)) begin : g_bad_params
        $error("pp_rca_pipe: WIDTH must be a positive multiple of SEG");
    end

    logic             stall_w;
    logic             en_w;
    pp_rca_ctl_t      in_ctl_w;
    logic [WIDTH-1:0] in_b_w;
    pp_rca_ctl_t      stg_ctl_q [NSTG];
    logic [WIDTH-1:0] stg_a_q   [NSTG];
    logic [WIDTH-1:0] stg_b_q   [NSTG];
    logic [WIDTH-1:0] stg_sum_q [NSTG];

    // A stalled output freezes the whole pipe; bubbles are never squeezed out.
    assign stall_w    = out_valid_o && !out_ready_i;
    assign en_w       = !stall_w;
    assign in_ready_o = en_w;

    // Subtraction is A + ~B + 1, so the stage-0 carry is forced high.
    assign in_b_w = sub_i ? ~b_i : b_i;

    always_comb begin
        in_ctl_w       = '0;
        in_ctl_w.valid = in_valid_i;
        in_ctl_w.carry = sub_i | cin_i;
    end

    for (genvar k = 0; k < NSTG; k++) begin : g_stage
        pp_rca_ctl_t      ctl_in_w;
        logic [WIDTH-1:0] a_in_w;
        logic [WIDTH-1:0] b_in_w;
        logic [WIDTH-1:0] sum_in_w;

        if (k == 0) begin : g_first
            assign ctl_in_w = in_ctl_w;
            assign a_in_w   = a_i;
            assign b_in_w   = in_b_w;
            assign sum_in_w = '0;
        end else begin : g_next
            assign ctl_in_w = stg_ctl_q[k-1];
            assign a_in_w   = stg_a_q[k-1];
            assign b_in_w   = stg_b_q[k-1];
            assign sum_in_w = stg_sum_q[k-1];
        end

        pp_rca_stage #(
            .WIDTH (WIDTH),
            .SEG   (SEG),
            .IDX   (k)
        ) u_stage (
            .clk   (clk),
            .rst_n (rst_n),
            .en_i  (en_w),
            .ctl_i (ctl_in_w),
            .a_i   (a_in_w),
            .b_i   (b_in_w),
            .sum_i (sum_in_w),
            .ctl_o (stg_ctl_q[k]),
            .a_o   (stg_a_q[k]),
            .b_o   (stg_b_q[k]),
            .sum_o (stg_sum_q[k])
        );
    end

    // The last stage register is the output register.
    assign out_valid_o = stg_ctl_q[NSTG-1].valid;
    assign s_o         = stg_sum_q[NSTG-1];
    assign cout_o      = stg_ctl_q[NSTG-1].carry;
`ifdef PP_RCA_OVF_EN
    assign ovf_o       = stg_ctl_q[NSTG-1].ovf;
`endif

endmodule
`default_nettype wire

// File: tb/tb_pp_rca_pipe.sv
`default_nettype none
// ============================================================================
// Module   : tb_pp_rca_pipe
// Brief    : Self-checking bench for pp_rca_pipe (16/4 and 32/8 instances).
//            Macro: PP_RCA_OVF_EN enables ovf checking.
// Revision : 1.0
// ============================================================================
module tb_pp_rca_pipe;

    localparam int NSTG = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic        in_valid, in_ready, cin, sub, out_valid, out_ready, cout;
    logic [15:0] a, b, s;
    logic        in_valid32, in_ready32, cin32, sub32, out_valid32, out_ready32, cout32;
    logic [31:0] a32, b32, s32;
`ifdef PP_RCA_OVF_EN
    logic        ovf, ovf32;
`endif

    pp_rca_pipe u_dut (
        .clk(clk), .rst_n(rst_n), .in_valid_i(in_valid), .in_ready_o(in_ready),
        .a_i(a), .b_i(b), .cin_i(cin), .sub_i(sub), .out_valid_o(out_valid),
        .out_ready_i(out_ready), .s_o(s), .cout_o(cout)
`ifdef PP_RCA_OVF_EN
        , .ovf_o(ovf)
`endif
    );

    pp_rca_pipe #(.WIDTH(32), .SEG(8)) u_dut32 (
        .clk(clk), .rst_n(rst_n), .in_valid_i(in_valid32), .in_ready_o(in_ready32),
        .a_i(a32), .b_i(b32), .cin_i(cin32), .sub_i(sub32), .out_valid_o(out_valid32),
        .out_ready_i(out_ready32), .s_o(s32), .cout_o(cout32)
`ifdef PP_RCA_OVF_EN
        , .ovf_o(ovf32)
`endif
    );

    typedef struct {
        logic [15:0] s;
        logic        c;
        logic        ov;
        int          cyc;
        int          st;
    } exp_t;

    int          checks = 0;
    int          failures = 0;
    int          cyc = 0;
    int          stall_total = 0;
    int          pops = 0;
    exp_t        q[$];
    logic [15:0] got_s[$];
    logic        got_c[$];
    int          got_cyc[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Reference arithmetic: plain integer add/subtract, signed range test for ovf.
    function automatic exp_t model(input logic [15:0] ta, input logic [15:0] tb,
                                   input logic tc, input logic ts);
        exp_t        e;
        logic [16:0] wide;
        int          ia, ib, sr;
        ia = int'($signed(ta));
        ib = int'($signed(tb));
        if (ts) begin
            e.s = ta - tb;
            e.c = (ta >= tb);
            sr  = ia - ib;
        end else begin
            wide = {1'b0, ta} + {1'b0, tb} + {16'b0, tc};
            e.s  = wide[15:0];
            e.c  = wide[16];
            sr   = ia + ib + int'(tc);
        end
        e.ov  = (sr > 32767) || (sr < -32768);
        e.cyc = 0;
        e.st  = 0;
        return e;
    endfunction

    always @(negedge clk) begin
        exp_t e;
        if (rst_n) begin
            chk("in_ready_rule", in_ready, !(out_valid && !out_ready));
            if (in_valid && in_ready) begin
                e     = model(a, b, cin, sub);
                e.cyc = cyc;
                e.st  = stall_total;
                q.push_back(e);
            end
            if (out_valid && out_ready) begin
                if (q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL spurious_result: got s=0x%0h expected no result", s);
                end else begin
                    e = q.pop_front();
                    chk("s", s, e.s);
                    chk("cout", cout, e.c);
                    chk("latency", cyc - e.cyc - (stall_total - e.st), NSTG);
`ifdef PP_RCA_OVF_EN
                    chk("ovf", ovf, e.ov);
`endif
                    got_s.push_back(s);
                    got_c.push_back(cout);
                    got_cyc.push_back(cyc);
                    pops++;
                end
            end
            if (out_valid && !out_ready) stall_total++;
        end
        cyc++;
    end

    task automatic send(input logic [15:0] ta, input logic [15:0] tb,
                        input logic tc, input logic ts);
        logic acc;
        in_valid = 1'b1;
        a = ta; b = tb; cin = tc; sub = ts;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            acc = in_ready;
            @(posedge clk);
            #1;
            if (acc) break;
            if (i == 49) begin
                checks++;
                failures++;
                $display("FAIL send_timeout: got in_ready=0 expected acceptance");
            end
        end
        in_valid = 1'b0;
    endtask

    task automatic wait_pops(input int target);
        for (int i = 0; i < 60; i++) begin
            if (pops >= target) break;
            @(posedge clk);
        end
        #1;
        if (pops < target) begin
            checks++;
            failures++;
            $display("FAIL wait_results: got %0d results expected %0d", pops, target);
        end
    endtask

    task automatic run32(input string name, input logic [31:0] ta, input logic [31:0] tb,
                         input logic tc, input logic ts, input logic [31:0] es,
                         input logic ec, input logic eo);
        int lat;
        lat = 0;
        a32 = ta; b32 = tb; cin32 = tc; sub32 = ts;
        in_valid32 = 1'b1;
        @(negedge clk);
        chk({name, "_ready"}, in_ready32, 1);
        @(posedge clk);
        #1;
        in_valid32 = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            lat++;
            if (out_valid32) break;
        end
        chk({name, "_latency"}, lat, 4);
        chk({name, "_s"}, s32, es);
        chk({name, "_cout"}, cout32, ec);
`ifdef PP_RCA_OVF_EN
        chk({name, "_ovf"}, ovf32, eo);
`else
        if (eo === 1'bx) $display("note: %s ovf expectation undefined", name);
`endif
        @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int st0;
        rst_n = 1'b0;
        in_valid = 1'b0; a = '0; b = '0; cin = 1'b0; sub = 1'b0; out_ready = 1'b1;
        in_valid32 = 1'b0; a32 = '0; b32 = '0; cin32 = 1'b0; sub32 = 1'b0; out_ready32 = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_hold_valid", out_valid, 0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_s", s, 0);
        chk("rst_cout", cout, 0);
        chk("rst_in_ready", in_ready, 1);
        chk("rst_out_valid32", out_valid32, 0);
        @(posedge clk);
        #1;

        // Single add
        send(16'h55F5, 16'h5448, 1'b0, 1'b0);
        wait_pops(1);
        chk("t1_s", got_s[0], 16'hAA3D);
        chk("t1_cout", got_c[0], 0);

        // Back-to-back adds
        send(16'h2424, 16'h0449, 1'b1, 1'b0);
        send(16'h2880, 16'h8241, 1'b0, 1'b0);
        wait_pops(3);
        chk("t2_s0", got_s[1], 16'h286E);
        chk("t2_s1", got_s[2], 16'hAAC1);
        chk("t2_cout0", got_c[1], 0);
        chk("t2_cout1", got_c[2], 0);
        chk("t2_consecutive", got_cyc[2] - got_cyc[1], 1);

        // Subtract; second one has cin=1, which must be ignored
        send(16'h0003, 16'h0005, 1'b0, 1'b1);
        send(16'h0005, 16'h0003, 1'b1, 1'b1);
        wait_pops(5);
        chk("t3_s0", got_s[3], 16'hFFFE);
        chk("t3_cout0", got_c[3], 0);
        chk("t3_s1", got_s[4], 16'h0002);
        chk("t3_cout1", got_c[4], 1);

        // Backpressure: 6-transaction stream, 3 stalled cycles mid-stream
        st0 = stall_total;
        fork
            begin
                send(16'h1234, 16'h1111, 1'b0, 1'b0);
                send(16'hFFFF, 16'h0001, 1'b0, 1'b0);
                send(16'h8000, 16'h8000, 1'b1, 1'b0);
                send(16'h0000, 16'h0001, 1'b0, 1'b1);
                send(16'h7FFF, 16'h0001, 1'b0, 1'b0);
                send(16'hABCD, 16'hABCD, 1'b1, 1'b1);
            end
            begin
                for (int i = 0; i < 20; i++) begin
                    @(negedge clk);
                    if (out_valid) break;
                end
                @(posedge clk);
                #1;
                out_ready = 1'b0;
                repeat (3) begin
                    @(negedge clk);
                    chk("t4_stall_in_ready", in_ready, 0);
                    chk("t4_stall_out_valid", out_valid, 1);
                end
                @(posedge clk);
                #1;
                out_ready = 1'b1;
            end
        join
        wait_pops(11);
        repeat (6) @(posedge clk);
        #1;
        chk("t4_count", pops, 11);
        chk("t4_queue_empty", q.size(), 0);
        chk("t4_stall_cycles", stall_total - st0, 3);
        chk("t4_s0", got_s[5], 16'h2345);
        chk("t4_s1", got_s[6], 16'h0000);
        chk("t4_cout1", got_c[6], 1);
        chk("t4_s5", got_s[10], 16'h0000);
        chk("t4_cout5", got_c[10], 1);

        // Reset with 3 transactions in flight, first one parked at the output
        out_ready = 1'b0;
        send(16'h1111, 16'h2222, 1'b0, 1'b0);
        send(16'h0F0F, 16'h0101, 1'b1, 1'b0);
        send(16'h9000, 16'h1000, 1'b0, 1'b1);
        @(posedge clk);
        #1;
        chk("t5_pre_valid", out_valid, 1);
        chk("t5_pre_s", s, 16'h3333);
        q.delete();
        rst_n = 1'b0;
        #1;
        chk("t5_rst_valid", out_valid, 0);
        chk("t5_rst_s", s, 0);
        chk("t5_rst_cout", cout, 0);
        chk("t5_rst_in_ready", in_ready, 1);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        out_ready = 1'b1;
        repeat (10) begin
            @(negedge clk);
            chk("t5_post_valid", out_valid, 0);
        end
        chk("t5_no_stale", pops, 11);
        @(posedge clk);
        #1;

        // 32-bit / 8-bit segment instance
        run32("t6_ovf", 32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 32'h8000_0000, 1'b0, 1'b1);
        run32("t6_sub", 32'h0000_0000, 32'h0000_0001, 1'b0, 1'b1, 32'hFFFF_FFFF, 1'b0, 1'b0);
        run32("t6_cin", 32'hFFFF_FFFF, 32'h0000_0000, 1'b1, 1'b0, 32'h0000_0000, 1'b1, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
